// File: rtl/axis_pkg.sv
// Shared types and default geometry for the AXI-stream metadata generator.
package axis_pkg;

    localparam int DATA_W_DEF  = 128;
    localparam int KEEP_W_DEF  = DATA_W_DEF / 8;
    localparam int KEEP_MASK_W = KEEP_W_DEF;
    // Byte offset counter; one spare bit above a 16-bit length.
    localparam int OFF_W       = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/axis_meta_beat_fmt.sv
// Builds one beat's payload and byte enables from the packet byte offset,
// packet length and the per-packet pattern base.
module axis_meta_beat_fmt
    import axis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic [OFF_W-1:0]  byte_off_i,
    input  logic [15:0]       len_i,
    input  logic [7:0]        seed_i,
    input  logic [7:0]        pkt_lsb_i,
    output logic [DATA_W-1:0] data_o,
    output logic [KEEP_W-1:0] keep_o,
    output logic              last_o
);

    int         rem_w;
    logic [7:0] base_w;

    always_comb begin
        rem_w  = int'(len_i) - int'(byte_off_i);
        last_o = (rem_w <= KEEP_W);
        base_w = seed_i + pkt_lsb_i + byte_off_i[7:0];
        data_o = '0;
        keep_o = '0;
        // Only the final beat can be partial; unused bytes stay zero.
        for (int j = 0; j < KEEP_W; j++) begin
            if (!last_o || (j < rem_w)) begin
                keep_o[j]         = 1'b1;
                data_o[8*j +: 8]  = base_w + 8'(j);
            end
        end
    end

endmodule

// File: rtl/axis_meta_gen.sv
// Burst generator: emits cfg_pkt_num packets of cfg_len bytes with a
// seeded incrementing byte pattern on an AXI-stream style interface.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for a start with legal length/count
// ST_SEND | presenting beats, advancing on vld && rdy
// ST_DONE | one-cycle completion pulse, then back to idle
module axis_meta_gen
    import axis_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       cfg_len,
    input  logic [15:0]       cfg_pkt_num,
    input  logic [3:0]        cfg_tid,
    input  logic [3:0]        cfg_tdt,
    input  logic [7:0]        cfg_seed,
    output logic [DATA_W-1:0] tx_meta_data,
    output logic [KEEP_W-1:0] tx_meta_keep,
    output logic              tx_meta_vld,
    output logic [3:0]        tx_meta_tid,
    output logic [3:0]        tx_meta_tdt,
    output logic              tx_meta_sop,
    output logic              tx_meta_eop,
    input  logic              tx_meta_rdy,
    output logic              busy,
    output logic              done
);

    state_e           state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      num_q, num_d;
    logic [3:0]       tid_q, tid_d;
    logic [3:0]       tdt_q, tdt_d;
    logic [7:0]       seed_q, seed_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [15:0]      pkt_q, pkt_d;

    logic [DATA_W-1:0] fmt_data;
    logic [KEEP_W-1:0] fmt_keep;
    logic              fmt_last;

    axis_meta_beat_fmt #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W)
    ) u_fmt (
        .byte_off_i (off_q),
        .len_i      (len_q),
        .seed_i     (seed_q),
        .pkt_lsb_i  (pkt_q[7:0]),
        .data_o     (fmt_data),
        .keep_o     (fmt_keep),
        .last_o     (fmt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            num_q   <= '0;
            tid_q   <= '0;
            tdt_q   <= '0;
            seed_q  <= '0;
            off_q   <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            num_q   <= num_d;
            tid_q   <= tid_d;
            tdt_q   <= tdt_d;
            seed_q  <= seed_d;
            off_q   <= off_d;
            pkt_q   <= pkt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        num_d   = num_q;
        tid_d   = tid_q;
        tdt_d   = tdt_q;
        seed_d  = seed_q;
        off_d   = off_q;
        pkt_d   = pkt_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (cfg_len != 16'd0) && (cfg_pkt_num != 16'd0)) begin
                    len_d   = cfg_len;
                    num_d   = cfg_pkt_num;
                    tid_d   = cfg_tid;
                    tdt_d   = cfg_tdt;
                    seed_d  = cfg_seed;
                    off_d   = '0;
                    pkt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_meta_rdy) begin
                    if (fmt_last) begin
                        if (pkt_q == num_q - 16'd1) begin
                            state_d = ST_DONE;
                        end else begin
                            pkt_d = pkt_q + 16'd1;
                            off_d = '0;
                        end
                    end else begin
                        off_d = off_q + OFF_W'(KEEP_W);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are gated by valid so that idle and reset drive all zeros.
    assign tx_meta_vld  = (state_q == ST_SEND);
    assign tx_meta_data = tx_meta_vld ? fmt_data : '0;
    assign tx_meta_keep = tx_meta_vld ? fmt_keep : '0;
    assign tx_meta_tid  = tx_meta_vld ? tid_q : 4'd0;
    assign tx_meta_tdt  = tx_meta_vld ? tdt_q : 4'd0;
    assign tx_meta_sop  = tx_meta_vld && (off_q == '0);
    assign tx_meta_eop  = tx_meta_vld && fmt_last;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_axis_meta_gen.sv
// Scoreboard bench for axis_meta_gen: a byte-level packet model fills the
// expected-beat queue, a negedge monitor pops and compares accepted beats.
module tb_axis_meta_gen;
    import axis_pkg::*;

    localparam int DW = 128;
    localparam int KW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   cfg_len = '0;
    logic [15:0]   cfg_pkt_num = '0;
    logic [3:0]    cfg_tid = '0;
    logic [3:0]    cfg_tdt = '0;
    logic [7:0]    cfg_seed = '0;
    logic [DW-1:0] tx_meta_data;
    logic [KW-1:0] tx_meta_keep;
    logic          tx_meta_vld;
    logic [3:0]    tx_meta_tid;
    logic [3:0]    tx_meta_tdt;
    logic          tx_meta_sop;
    logic          tx_meta_eop;
    logic          tx_meta_rdy = 1'b0;
    logic          busy;
    logic          done;

    axis_meta_gen #(.DATA_W(DW), .KEEP_W(KW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_len      (cfg_len),
        .cfg_pkt_num  (cfg_pkt_num),
        .cfg_tid      (cfg_tid),
        .cfg_tdt      (cfg_tdt),
        .cfg_seed     (cfg_seed),
        .tx_meta_data (tx_meta_data),
        .tx_meta_keep (tx_meta_keep),
        .tx_meta_vld  (tx_meta_vld),
        .tx_meta_tid  (tx_meta_tid),
        .tx_meta_tdt  (tx_meta_tdt),
        .tx_meta_sop  (tx_meta_sop),
        .tx_meta_eop  (tx_meta_eop),
        .tx_meta_rdy  (tx_meta_rdy),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          sop;
        logic          eop;
        logic [3:0]    tid;
        logic [3:0]    tdt;
        bit            burst_end;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    accepted = 0;
    int    dones = 0;
    bit    done_expected = 0;
    bit    prev_stall = 0;
    bit    rdy_random = 0;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference model: byte i of packet p is seed + p + i (mod 256).
    task automatic push_burst(input int len, input int num, input logic [3:0] tid,
                              input logic [3:0] tdt, input logic [7:0] seed);
        int nb;
        nb = (len + KW - 1) / KW;
        for (int p = 0; p < num; p++) begin
            for (int b = 0; b < nb; b++) begin
                beat_t e;
                e.data = '0;
                e.keep = '0;
                for (int j = 0; j < KW; j++) begin
                    int off;
                    off = b * KW + j;
                    if (off < len) begin
                        e.keep[j]       = 1'b1;
                        e.data[8*j +: 8] = 8'((int'(seed) + p + off) % 256);
                    end
                end
                e.sop       = (b == 0);
                e.eop       = (b == nb - 1);
                e.tid       = tid;
                e.tdt       = tdt;
                e.burst_end = (p == num - 1) && (b == nb - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_meta_rdy = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall    = 0;
                done_expected = 0;
            end else begin
                if (done) dones++;
                if (done_expected) begin
                    chk(done && !tx_meta_vld, "done_pulse", {done, tx_meta_vld}, 2'b10);
                    done_expected = 0;
                end else if (done) begin
                    chk(1'b0, "unexpected_done", done, 1'b0);
                end
                if (prev_stall) chk(tx_meta_vld, "vld_hold", tx_meta_vld, 1'b1);
                if (tx_meta_vld) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_beat", tx_meta_data, '0);
                    end else if (tx_meta_rdy) begin
                        beat_t e;
                        e = exp_q.pop_front();
                        n_checks++;
                        if ({tx_meta_data, tx_meta_keep, tx_meta_sop, tx_meta_eop, tx_meta_tid, tx_meta_tdt}
                            !== {e.data, e.keep, e.sop, e.eop, e.tid, e.tdt}) begin
                            n_fail++;
                            $display("FAIL beat %0d: got data=%h keep=%h sop=%b eop=%b tid=%h tdt=%h, expected data=%h keep=%h sop=%b eop=%b tid=%h tdt=%h",
                                     accepted, tx_meta_data, tx_meta_keep, tx_meta_sop, tx_meta_eop, tx_meta_tid, tx_meta_tdt,
                                     e.data, e.keep, e.sop, e.eop, e.tid, e.tdt);
                        end
                        accepted++;
                        if (e.burst_end) done_expected = 1;
                    end
                end
                prev_stall = tx_meta_vld && !tx_meta_rdy;
            end
        end
    end

    task automatic pulse_start(input logic [15:0] len, input logic [15:0] num, input logic [3:0] tid,
                               input logic [3:0] tdt, input logic [7:0] seed);
        @(posedge clk);
        #1;
        cfg_len     = len;
        cfg_pkt_num = num;
        cfg_tid     = tid;
        cfg_tdt     = tdt;
        cfg_seed    = seed;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        cfg_len     = 16'($urandom);
        cfg_pkt_num = 16'($urandom);
        cfg_tid     = 4'($urandom);
        cfg_tdt     = 4'($urandom);
        cfg_seed    = 8'($urandom);
    endtask

    task automatic wait_done(input int d0, input string name);
        int cyc;
        cyc = 0;
        while (dones == d0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk(dones == d0 + 1, name, dones, d0 + 1);
        @(negedge clk);
        chk(exp_q.size() == 0, {name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic do_burst(input int len, input int num, input logic [7:0] seed, input bit rnd);
        logic [3:0] tid;
        logic [3:0] tdt;
        int         d0;
        tid        = 4'($urandom);
        tdt        = 4'($urandom);
        rdy_random = rnd;
        d0         = dones;
        push_burst(len, num, tid, tdt, seed);
        pulse_start(16'(len), 16'(num), tid, tdt, seed);
        chk(tx_meta_vld && busy, "first_beat_vld", {tx_meta_vld, busy}, 2'b11);
        wait_done(d0, "burst_done");
    endtask

    task automatic illegal_start(input logic [15:0] len, input logic [15:0] num);
        bit seen_busy;
        int d0;
        rdy_random = 0;
        d0 = dones;
        pulse_start(len, num, 4'h3, 4'h5, 8'h11);
        seen_busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || tx_meta_vld) seen_busy = 1;
        end
        chk(!seen_busy, "illegal_idle", seen_busy, 1'b0);
        chk(dones == d0, "illegal_no_done", dones, d0);
    endtask

    initial begin
        int d0;
        int a0;
        int cyc;
        repeat (3) @(negedge clk);
        chk(tx_meta_vld == 1'b0, "rst_vld", tx_meta_vld, 1'b0);
        chk(busy == 1'b0, "rst_busy", busy, 1'b0);
        chk(done == 1'b0, "rst_done", done, 1'b0);
        chk(tx_meta_data == '0, "rst_data", tx_meta_data, '0);
        chk(tx_meta_keep == '0, "rst_keep", tx_meta_keep, '0);
        chk({tx_meta_sop, tx_meta_eop, tx_meta_tid, tx_meta_tdt} == '0, "rst_misc",
            {tx_meta_sop, tx_meta_eop, tx_meta_tid, tx_meta_tdt}, '0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        do_burst(16, 1, 8'h00, 0);
        do_burst(40, 2, 8'hFE, 0);
        do_burst(33, 1, 8'h5A, 1);
        for (int k = 0; k < 8; k++) begin
            do_burst($urandom_range(1, 100), $urandom_range(1, 4), 8'($urandom), 1);
        end
        do_burst(1, 3, 8'hFF, 1);
        do_burst(32, 2, 8'h80, 1);

        illegal_start(16'd0, 16'd3);
        illegal_start(16'd20, 16'd0);

        // Reset in the middle of a 5-beat packet.
        rdy_random = 0;
        d0 = dones;
        a0 = accepted;
        push_burst(80, 1, 4'h2, 4'h9, 8'h33);
        pulse_start(16'd80, 16'd1, 4'h2, 4'h9, 8'h33);
        cyc = 0;
        while (accepted < a0 + 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk(accepted >= a0 + 2, "pre_reset_beats", accepted, a0 + 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk(tx_meta_vld == 1'b0, "async_rst_vld", tx_meta_vld, 1'b0);
        chk(busy == 1'b0, "async_rst_busy", busy, 1'b0);
        chk(tx_meta_eop == 1'b0, "async_rst_eop", tx_meta_eop, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk(dones == d0, "reset_no_done", dones, d0);
        do_burst(80, 1, 8'h44, 0);

        // Start re-pulsed with a new length while the burst is running.
        rdy_random = 1;
        d0 = dones;
        push_burst(48, 3, 4'hA, 4'h6, 8'hC0);
        pulse_start(16'd48, 16'd3, 4'hA, 4'h6, 8'hC0);
        repeat (3) @(posedge clk);
        #1;
        cfg_len = 16'd16;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        wait_done(d0, "restart_done");
        repeat (30) @(negedge clk);
        chk(dones == d0 + 1, "restart_single_burst", dones, d0 + 1);
        chk(busy == 1'b0, "restart_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
